// File: rtl/yutorina_id_fwd_stage_pkg.sv
// Shared widths, the NOP control encoding and the bubble-counter helper
// for the Yutorina decode/forwarding stage.
package yutorina_id_fwd_stage_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_PC_W     = 30;
  localparam int DEF_GPR_AW   = 5;
  localparam int DEF_CTL_W    = 16;
  localparam int DEF_NUM_FWD  = 2;
  localparam int BUBBLE_CNT_W = 16;

  localparam logic [DEF_CTL_W-1:0] CTL_NOP = '0;

  function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
    sat_inc = (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/yutorina_fwd_mux.sv
// Priority forwarding match for one operand: the lowest-index (nearest)
// valid source whose destination equals the operand address wins.
module yutorina_fwd_mux
  import yutorina_id_fwd_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int GPR_AW  = DEF_GPR_AW,
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic [GPR_AW-1:0]         addr,
  input  logic [DATA_W-1:0]         gpr_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*GPR_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         value,
  output logic                      hit,
  output logic                      pending
);

  // Walk oldest to nearest so the nearest match overwrites; r0 never matches.
  always_comb begin
    value   = gpr_data;
    hit     = 1'b0;
    pending = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (addr != '0) && (fwd_addr[k*GPR_AW +: GPR_AW] == addr)) begin
        value   = fwd_data[k*DATA_W +: DATA_W];
        hit     = 1'b1;
        pending = fwd_pending[k];
      end
    end
  end

endmodule

// File: rtl/yutorina_id_fwd_stage.sv
// Decode-stage pipeline register: resolves operands through the forwarding
// network, detects load-use / pending-producer hazards and inserts bubbles.
module yutorina_id_fwd_stage
  import yutorina_id_fwd_stage_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_W    = DEF_PC_W,
  parameter int GPR_AW  = DEF_GPR_AW,
  parameter int CTL_W   = DEF_CTL_W,
  parameter int NUM_FWD = DEF_NUM_FWD
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [PC_W-1:0]           in_pc,
  input  logic [CTL_W-1:0]          in_ctl,
  input  logic [GPR_AW-1:0]         in_rs1,
  input  logic [GPR_AW-1:0]         in_rs2,
  input  logic                      in_use_rs1,
  input  logic                      in_use_rs2,
  input  logic [GPR_AW-1:0]         in_rd,
  input  logic                      in_we,
  input  logic                      in_is_load,
  input  logic [DATA_W-1:0]         gpr_r_data1,
  input  logic [DATA_W-1:0]         gpr_r_data2,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD-1:0]        fwd_pending,
  input  logic [NUM_FWD*GPR_AW-1:0] fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         rs1_val,
  output logic [DATA_W-1:0]         rs2_val,
  output logic                      haz,
  output logic                      id_valid,
  output logic [PC_W-1:0]           id_pc,
  output logic [CTL_W-1:0]          id_ctl,
  output logic [DATA_W-1:0]         id_rs1_val,
  output logic [DATA_W-1:0]         id_rs2_val,
  output logic [GPR_AW-1:0]         id_rd,
  output logic                      id_we,
  output logic                      id_is_load,
  output logic [BUBBLE_CNT_W-1:0]   bubble_cnt
);

  logic hit1, hit2, pend1, pend2;
  logic int_match1, int_match2, haz1, haz2;

  yutorina_fwd_mux #(.DATA_W(DATA_W), .GPR_AW(GPR_AW), .NUM_FWD(NUM_FWD)) u_mux1 (
    .addr(in_rs1), .gpr_data(gpr_r_data1), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .value(rs1_val), .hit(hit1), .pending(pend1)
  );

  yutorina_fwd_mux #(.DATA_W(DATA_W), .GPR_AW(GPR_AW), .NUM_FWD(NUM_FWD)) u_mux2 (
    .addr(in_rs2), .gpr_data(gpr_r_data2), .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .value(rs2_val), .hit(hit2), .pending(pend2)
  );

  // The EX-bound register is the nearest candidate but only ever a hazard
  // source; a non-load match there wins and masks older pending producers.
  assign int_match1 = id_valid && id_we && (id_rd != '0) && (id_rd == in_rs1);
  assign int_match2 = id_valid && id_we && (id_rd != '0) && (id_rd == in_rs2);
  assign haz1 = in_use_rs1 && (int_match1 ? id_is_load : (hit1 && pend1));
  assign haz2 = in_use_rs2 && (int_match2 ? id_is_load : (hit2 && pend2));

  // Upstream handshake: haz=1 means the decoder must hold and re-present the
  // same instruction next cycle; stall=1 freezes this stage entirely.
  assign haz = in_valid && (haz1 || haz2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid   <= 1'b0;
      id_pc      <= '0;
      id_ctl     <= '0;
      id_rs1_val <= '0;
      id_rs2_val <= '0;
      id_rd      <= '0;
      id_we      <= 1'b0;
      id_is_load <= 1'b0;
      bubble_cnt <= '0;
    end else if (!stall) begin
      id_pc <= in_pc;
      if (flush || haz || !in_valid) begin
        id_valid   <= 1'b0;
        id_ctl     <= CTL_W'(CTL_NOP);
        id_rs1_val <= '0;
        id_rs2_val <= '0;
        id_rd      <= '0;
        id_we      <= 1'b0;
        id_is_load <= 1'b0;
      end else begin
        id_valid   <= 1'b1;
        id_ctl     <= in_ctl;
        id_rs1_val <= rs1_val;
        id_rs2_val <= rs2_val;
        id_rd      <= in_rd;
        id_we      <= in_we;
        id_is_load <= in_is_load;
      end
      if (!flush && haz) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

endmodule

// File: tb/tb_yutorina_id_fwd_stage.sv
// Directed bench for yutorina_id_fwd_stage: forwarding priority, hazards,
// stall/flush, counter saturation and asynchronous reset.
module tb_yutorina_id_fwd_stage;

  localparam int DATA_W  = 32;
  localparam int PC_W    = 30;
  localparam int GPR_AW  = 5;
  localparam int CTL_W   = 16;
  localparam int NUM_FWD = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      stall, flush, in_valid;
  logic [PC_W-1:0]           in_pc;
  logic [CTL_W-1:0]          in_ctl;
  logic [GPR_AW-1:0]         in_rs1, in_rs2, in_rd;
  logic                      in_use_rs1, in_use_rs2, in_we, in_is_load;
  logic [DATA_W-1:0]         gpr_r_data1, gpr_r_data2;
  logic [NUM_FWD-1:0]        fwd_valid, fwd_pending;
  logic [NUM_FWD*GPR_AW-1:0] fwd_addr;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0]         rs1_val, rs2_val, id_rs1_val, id_rs2_val;
  logic                      haz, id_valid, id_we, id_is_load;
  logic [PC_W-1:0]           id_pc;
  logic [CTL_W-1:0]          id_ctl;
  logic [GPR_AW-1:0]         id_rd;
  logic [15:0]               bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  yutorina_id_fwd_stage #(
    .DATA_W(DATA_W), .PC_W(PC_W), .GPR_AW(GPR_AW), .CTL_W(CTL_W), .NUM_FWD(NUM_FWD)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_ctl(in_ctl), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2), .in_rd(in_rd), .in_we(in_we),
    .in_is_load(in_is_load), .gpr_r_data1(gpr_r_data1), .gpr_r_data2(gpr_r_data2),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .haz(haz), .id_valid(id_valid), .id_pc(id_pc),
    .id_ctl(id_ctl), .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_rd(id_rd),
    .id_we(id_we), .id_is_load(id_is_load), .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    stall = 0; flush = 0; in_valid = 0; in_pc = '0; in_ctl = '0;
    in_rs1 = '0; in_rs2 = '0; in_use_rs1 = 0; in_use_rs2 = 0;
    in_rd = '0; in_we = 0; in_is_load = 0;
    gpr_r_data1 = '0; gpr_r_data2 = '0;
    fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;
  endtask

  task automatic test_reset();
    clear_in();
    rst = 0;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
    checks++; if (id_pc !== 30'h0) begin errors++; $display("FAIL reset_id_pc: got %h want 0", id_pc); end
    checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL reset_bubble_cnt: got %h want 0", bubble_cnt); end
    checks++; if (haz !== 1'b0) begin errors++; $display("FAIL reset_haz: got %b want 0", haz); end
    rst = 1;
    step();
  endtask

  task automatic test_basic();
    clear_in();
    in_valid = 1; in_pc = 30'h10; in_rs1 = 5'd3; in_use_rs1 = 1; gpr_r_data1 = 32'hAA;
    in_ctl = 16'h1234; in_rd = 5'd7; in_we = 1;
    #1;
    checks++; if (haz !== 1'b0) begin errors++; $display("FAIL basic_haz: got %b want 0", haz); end
    checks++; if (rs1_val !== 32'hAA) begin errors++; $display("FAIL basic_rs1_val: got %h want aa", rs1_val); end
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL basic_id_valid: got %b want 1", id_valid); end
    checks++; if (id_pc !== 30'h10) begin errors++; $display("FAIL basic_id_pc: got %h want 10", id_pc); end
    checks++; if (id_rs1_val !== 32'hAA) begin errors++; $display("FAIL basic_id_rs1_val: got %h want aa", id_rs1_val); end
    checks++; if (id_ctl !== 16'h1234) begin errors++; $display("FAIL basic_id_ctl: got %h want 1234", id_ctl); end
    checks++; if (id_rd !== 5'd7) begin errors++; $display("FAIL basic_id_rd: got %0d want 7", id_rd); end
  endtask

  task automatic test_fwd_priority();
    fwd_valid = 2'b11; fwd_addr = {5'd3, 5'd3}; fwd_data = {32'h22, 32'h11};
    in_rs2 = 5'd3; gpr_r_data2 = 32'hCC;
    #1;
    checks++; if (rs1_val !== 32'h11) begin errors++; $display("FAIL fwd_nearest: got %h want 11", rs1_val); end
    checks++; if (rs2_val !== 32'h11) begin errors++; $display("FAIL fwd_nearest_rs2: got %h want 11", rs2_val); end
    fwd_valid = 2'b10;
    #1;
    checks++; if (rs1_val !== 32'h22) begin errors++; $display("FAIL fwd_older: got %h want 22", rs1_val); end
    fwd_valid = 2'b11; fwd_addr = {5'd0, 5'd0}; in_rs1 = 5'd0; gpr_r_data1 = 32'hBB;
    #1;
    checks++; if (rs1_val !== 32'hBB) begin errors++; $display("FAIL fwd_r0: got %h want bb", rs1_val); end
    fwd_valid = '0; in_rs2 = '0;
  endtask

  task automatic test_load_use();
    clear_in();
    in_valid = 1; in_is_load = 1; in_we = 1; in_rd = 5'd4; in_pc = 30'h20;
    #1;
    checks++; if (haz !== 1'b0) begin errors++; $display("FAIL ld_pre_haz: got %b want 0", haz); end
    step();
    checks++; if (id_is_load !== 1'b1) begin errors++; $display("FAIL ld_id_is_load: got %b want 1", id_is_load); end
    in_is_load = 0; in_rd = 5'd6; in_rs2 = 5'd4; in_use_rs2 = 1; gpr_r_data2 = 32'h99; in_pc = 30'h24;
    #1;
    checks++; if (haz !== 1'b1) begin errors++; $display("FAIL ld_use_haz: got %b want 1", haz); end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL ld_bubble_valid: got %b want 0", id_valid); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL ld_bubble_cnt: got %0d want 1", bubble_cnt); end
    checks++; if (id_pc !== 30'h24) begin errors++; $display("FAIL ld_bubble_pc: got %h want 24", id_pc); end
    fwd_valid = 2'b10; fwd_addr = {5'd4, 5'd0}; fwd_data = {32'h55, 32'h0};
    #1;
    checks++; if (haz !== 1'b0) begin errors++; $display("FAIL ld_resolve_haz: got %b want 0", haz); end
    checks++; if (rs2_val !== 32'h55) begin errors++; $display("FAIL ld_resolve_rs2: got %h want 55", rs2_val); end
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL ld_next_valid: got %b want 1", id_valid); end
    checks++; if (id_rs2_val !== 32'h55) begin errors++; $display("FAIL ld_next_rs2: got %h want 55", id_rs2_val); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL ld_cnt_hold: got %0d want 1", bubble_cnt); end
  endtask

  task automatic test_pending_mask();
    clear_in();
    in_valid = 1; in_rs1 = 5'd5; in_use_rs1 = 1; in_rd = 5'd9; in_we = 1;
    fwd_valid = 2'b11; fwd_addr = {5'd5, 5'd5}; fwd_data = {32'h77, 32'h66}; fwd_pending = 2'b10;
    #1;
    checks++; if (haz !== 1'b0) begin errors++; $display("FAIL mask_haz: got %b want 0", haz); end
    checks++; if (rs1_val !== 32'h66) begin errors++; $display("FAIL mask_val: got %h want 66", rs1_val); end
    fwd_pending = 2'b01;
    #1;
    checks++; if (haz !== 1'b1) begin errors++; $display("FAIL pend_near_haz: got %b want 1", haz); end
    in_use_rs1 = 0;
    #1;
    checks++; if (haz !== 1'b0) begin errors++; $display("FAIL pend_unused_haz: got %b want 0", haz); end
    in_use_rs1 = 1;
  endtask

  task automatic test_stall_flush();
    // Stage holds the valid rd=6 instruction from the load-use test.
    stall = 1;
    #1;
    checks++; if (haz !== 1'b1) begin errors++; $display("FAIL stall_haz_active: got %b want 1", haz); end
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stall_id_valid: got %b want 1", id_valid); end
    checks++; if (id_rd !== 5'd6) begin errors++; $display("FAIL stall_id_rd: got %0d want 6", id_rd); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt: got %0d want 1", bubble_cnt); end
    stall = 0; flush = 1;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_haz_valid: got %b want 0", id_valid); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL flush_haz_cnt: got %0d want 1", bubble_cnt); end
    fwd_valid = '0; fwd_pending = '0; in_ctl = 16'hBEEF; in_we = 1; in_rd = 5'd8;
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", id_valid); end
    checks++; if (id_we !== 1'b0) begin errors++; $display("FAIL flush_we: got %b want 0", id_we); end
    checks++; if (id_ctl !== 16'h0) begin errors++; $display("FAIL flush_ctl: got %h want 0", id_ctl); end
    flush = 0;
  endtask

  task automatic test_saturation();
    clear_in();
    rst = 0; #2; rst = 1;
    in_valid = 1; in_rs1 = 5'd5; in_use_rs1 = 1;
    fwd_valid = 2'b01; fwd_addr = {5'd0, 5'd5}; fwd_pending = 2'b01;
    repeat (65535) step();
    checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", bubble_cnt); end
    step();
    checks++; if (bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", bubble_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_in();
    in_valid = 1; in_pc = 30'h40; in_ctl = 16'h0F0F; in_rd = 5'd2; in_we = 1; in_is_load = 1;
    in_rs1 = 5'd1; gpr_r_data1 = 32'h1234;
    step();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", id_valid); end
    #2; rst = 0; #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", id_valid); end
    checks++; if (id_pc !== 30'h0) begin errors++; $display("FAIL mid_pc: got %h want 0", id_pc); end
    checks++; if (id_ctl !== 16'h0) begin errors++; $display("FAIL mid_ctl: got %h want 0", id_ctl); end
    checks++; if (id_rs1_val !== 32'h0) begin errors++; $display("FAIL mid_rs1: got %h want 0", id_rs1_val); end
    checks++; if (id_is_load !== 1'b0) begin errors++; $display("FAIL mid_is_load: got %b want 0", id_is_load); end
    checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL mid_cnt: got %h want 0", bubble_cnt); end
    rst = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fwd_priority();
    test_load_use();
    test_pending_mask();
    test_stall_flush();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yutorina_id_fwd_stage.md
# yutorina_id_fwd_stage

Parametrised decode-stage pipeline register for the Yutorina CPU, sitting between the instruction decoder and the EX stage. Takes an already-decoded instruction bundle and resolves its source operands through an N-source forwarding network, nearest stage first, with register 0 never forwarded. Detects load-use and pending-producer hazards, inserting bubbles and requesting an upstream stall. Honours stall/flush and keeps a saturating bubble counter for performance monitoring.

## Interface
- DATA_W, 32, data word width
- PC_W, 30, word-address PC width
- GPR_AW, 5, GPR address width
- CTL_W, 16, packed control bundle width (alu_op/mem_op/ctrl_op/exp_code)
- NUM_FWD, 2, forwarding sources; index 0 is nearest (EX), increasing index means older
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hold all registers
- flush  in  1  squash the instruction being registered
- in_valid  in  1  decoded instruction present
- in_pc  in  PC_W  instruction PC
- in_ctl  in  CTL_W  decoded control bundle
- in_rs1, in_rs2  in  GPR_AW  source addresses
- in_use_rs1, in_use_rs2  in  1  source actually read
- in_rd  in  GPR_AW  destination
- in_we  in  1  GPR write enable, active-high
- in_is_load  in  1  instruction is a memory read
- gpr_r_data1, gpr_r_data2  in  DATA_W  register-file read data
- fwd_valid  in  NUM_FWD  source k holds a GPR-writing instruction
- fwd_pending  in  NUM_FWD  source k result not yet available
- fwd_addr  in  NUM_FWD*GPR_AW  destination of source k
- fwd_data  in  NUM_FWD*DATA_W  result of source k
- rs1_val, rs2_val  out  DATA_W  forwarded operands (combinational, for ID branch compare)
- haz  out  1  hazard; upstream must hold IF/decoder
- id_valid, id_pc, id_ctl, id_rs1_val, id_rs2_val, id_rd, id_we, id_is_load  out  registered bundle to EX
- bubble_cnt  out  16  hazard bubbles inserted

## Operation
- Forwarding, per operand: the candidate list is the internal EX-bound register (id_valid & id_we & id_rd!=0, using data = pending if id_is_load), then fwd sources 0..NUM_FWD-1 (fwd_valid & fwd_addr!=0). The first address match wins; with no match, the value is gpr_r_dataN. Address 0 always yields gpr data.
- The internal stage is only a hazard source. It never supplies data, because EX data arrives via fwd index 0 on the following cycle.
- Hazard: haz = in_valid & (for a used source, the winning match is the internal load or a source with fwd_pending=1). A nearer non-pending match masks an older pending one.
- Register update priority: reset > stall (hold everything, including bubble_cnt) > flush > haz > normal.
- Flush or haz or !in_valid: load a bubble (id_valid=0, id_we=0, id_is_load=0, id_ctl=0 = CTL_NOP, id_rd=0, id_pc=in_pc, operands 0).
- Normal: register all in_* fields, with id_rs1_val/id_rs2_val = rs1_val/rs2_val.
- bubble_cnt increments on every haz-caused bubble (not flush) and saturates at 16'hFFFF.

## Timing
- Reset values: id_valid=0, id_pc=0, id_ctl=0, id_rs*_val=0, id_rd=0, id_we=0, id_is_load=0, bubble_cnt=0. haz follows from inputs, so it is 0 with in_valid=0.
- Latency: 1 cycle from in_* to id_*. rs*_val and haz are combinational in the same cycle.
- Load-use: a load in the id_* register plus a dependent in_* instruction gives haz=1 for exactly one cycle and one bubble. The next cycle resolves via fwd index 1 unless that source is pending.
- stall with haz=1: hold, no bubble, counter unchanged.
- flush and haz in the same cycle: flush wins, counter unchanged.
- Reset asserted mid-operation clears all registers immediately and asynchronously.

## Structure
- The shared package or header holds CTL_NOP, the default widths, and the bubble-counter width.
- One sub-module, yutorina_fwd_mux: a NUM_FWD-source priority match returning value, hit and pending. It is instantiated once per operand.

## Test plan
- Reset, then in_valid=1, pc=0x10, rs1=3, gpr_r_data1=0xAA with no fwd valid -> next cycle id_valid=1, id_pc=0x10, id_rs1_val=0xAA, haz=0.
- fwd0 = (r3, 0x11) and fwd1 = (r3, 0x22), both valid, reading r3 -> rs1_val=0x11 (nearest wins). Reading r0 with fwd0 addr 0 -> gpr data.
- Load r4 registered, next instruction uses rs2=r4 -> haz=1 for one cycle, id_valid=0 bubble, bubble_cnt=1. The following cycle, fwd1 = (r4, 0x55) non-pending -> rs2_val=0x55, haz=0.
- fwd0 matches r5 non-pending while fwd1 matches r5 pending -> haz=0, value = fwd0 data.
- stall=1 during a hazard -> id_* unchanged, bubble_cnt unchanged. flush=1 with a valid instruction -> id_valid=0, id_we=0, id_ctl=0.
- Force 65535 hazard bubbles then one more -> bubble_cnt stays 16'hFFFF. Pulse rst low mid-stream -> all outputs return to reset values.
